tdm_mux4: RTL

- 4-channel round-robin multiplexer and serializer; transmit-side counterpart of the 1-to-4 select demux.
- Arbitrates four valid/ready input lanes onto one registered output stream.
- Each output word carries a 2-bit channel select, so a downstream demux can route it back to the matching lane.
- Sits between the per-channel producers and the shared link.

---
 rtl/tdm_mux4.sv | 88 ++++++++
 1 files changed

// File: rtl/tdm_mux4.sv
// tdm_mux4: four valid/ready lanes arbitrated round-robin onto one registered output stream tagged with its source lane.
// Optional macro TDM_MUX_PARITY_EN adds out_parity, the XOR of out_data registered alongside it.
module tdm_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [1:0]         out_sel,
  output logic [WIDTH-1:0]   out_data,
`ifdef TDM_MUX_PARITY_EN
  output logic               out_parity,
`endif
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] rr_ptr;
  logic       grant_any;
  logic [1:0] grant_idx;
  logic       can_load;
  logic       load;

  // Walk from the highest offset down so the lane nearest rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[rr_ptr + 2'(k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_ptr + 2'(k);
      end
    end
  end

  assign can_load = (state == EMPTY) || out_ready;
  // rst_n gating keeps in_ready low while reset is held, even with lanes pending.
  assign load     = can_load && grant_any && rst_n;

  always_comb begin
    in_ready   = 4'b0000;
    state_next = state;
    if (load) begin
      in_ready[grant_idx] = 1'b1;
      state_next          = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sel  <= 2'd0;
      out_data <= '0;
      rr_ptr   <= 2'd0;
`ifdef TDM_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (load) begin
      out_sel  <= grant_idx;
      out_data <= in_data[grant_idx*WIDTH +: WIDTH];
      rr_ptr   <= grant_idx + 2'd1;
`ifdef TDM_MUX_PARITY_EN
      out_parity <= ^in_data[grant_idx*WIDTH +: WIDTH];
`endif
    end
  end

  assign out_valid = (state == FULL);

endmodule
